mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the five-stage MIPS pipeline. It accepts `md_sel` operations in the E stage, runs mult/multu/div/divu for a fixed number of cycles, and services mthi/mtlo/mfhi/mflo. It raises a D-stage stall request while any HI/LO-class instruction would otherwise collide with an in-flight operation.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu, range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu, range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: reset is synchronous and active-low. Asserted (0) at a rising edge, it clears all state.
- `md_sel` input 4: E-stage operation code.
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mfhi
  - 6 mflo
  - 7 mthi
  - 8 mtlo
  - 9..15 are treated as none.
- `a` input 32: forwarded rs value from E stage.
- `b` input 32: forwarded rt value from E stage.
- `d_md_use` input 1: the D-stage instruction is md, mt or mf class.
- `start` output 1: combinational; high in the cycle a mult/multu/div/divu is accepted.
- `busy` output 1: registered; high while an operation is in flight.
- `stall_md` output 1: combinational; equals `d_md_use & (start | busy)`.
- `md_out` output 32: combinational.
  - `hi` when `md_sel`=5.
  - `lo` when `md_sel`=6.
  - 0 otherwise.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.

## Operation
- States: IDLE and BUSY. A 4-bit down-counter `cnt` and two 32-bit pending-result registers `hi_p`/`lo_p` are held internally.
- IDLE, `md_sel` in 1..4:
  - `start`=1.
  - At the edge, compute the result into `hi_p`/`lo_p`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES and go to BUSY.
- Arithmetic:
  - mult: 64-bit signed product of `a` and `b`; upper half to HI, lower half to LO.
  - multu: same as mult, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: same as div, unsigned.
  - `b`=0 on div/divu: the operation still runs for the full DIV_CYCLES with busy asserted, but `hi`/`lo` stay unchanged at completion.
- BUSY:
  - `cnt` decrements each edge.
  - At the edge where `cnt` is 1: `hi`<=`hi_p`, `lo`<=`lo_p` (unless div-by-zero), `cnt`<=0, go to IDLE.
- mthi/mtlo, IDLE only: `hi` (or `lo`) <= `a` at the edge. There is no busy and no start.
- mfhi/mflo: pure combinational read of the current `hi`/`lo`. The value is valid only in IDLE.
- Any `md_sel`≠0 presented while BUSY is ignored: no state change and `start`=0. The `stall_md` protocol guarantees this never happens legitimately.
- Reset (`reset`=0 at an edge), including mid-operation:
  - state IDLE, `cnt`=0, `busy`=0.
  - `hi`=`lo`=`hi_p`=`lo_p`=0.
  - The pending result is discarded.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0. `start`, `stall_md` and `md_out` follow their combinational definitions (0 with `md_sel`=0, `d_md_use`=0).
- Issue in cycle T:
  - `start`=1 in T.
  - `busy`=1 in cycles T+1 .. T+N, where N is MULT_CYCLES or DIV_CYCLES.
  - `hi`/`lo` show the new result from cycle T+N+1.
  - `busy`=0 in T+N+1.
- Back-to-back: a new md op may be accepted in cycle T+N+1, with `start`=1 again.
- `stall_md` is high from cycle T through T+N whenever `d_md_use`=1. A dependent mfhi held in D therefore enters E in T+N+1 and reads the new value.
- mthi/mtlo written in cycle T are visible on `hi`/`lo`/`md_out` from T+1.
- Simultaneous events:
  - reset and issue in the same edge: reset wins, state IDLE, nothing is captured.
  - Completion edge and reset: reset wins.

## Test plan
- mult, `a`=0xFFFFFFFD (-3), `b`=5:
  - `start`=1 for one cycle, then `busy`=1 for exactly 5 cycles.
  - Afterwards `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - multu on the same operands gives `hi`=0x00000004, `lo`=0xFFFFFFF1.
- div and divu, each with `busy`=1 for 10 cycles:
  - div `a`=0xFFFFFFF9 (-7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - divu `a`=7, `b`=2 → `lo`=3, `hi`=1.
- div-by-zero, after mthi 0x1234 and mtlo 0x5678: div `a`=9, `b`=0 → `busy` high for 10 cycles; `hi`=0x1234 and `lo`=0x5678 unchanged.
- Stall:
  - Issue mult with `d_md_use`=1 held → `stall_md`=1 for cycles T..T+5 and 0 in T+6.
  - A mfhi presented in T+6 returns the product on `md_out`.
  - An md op presented during BUSY leaves `hi`/`lo`/`cnt` unaffected.
- Reset mid-operation: issue divu 100/7, assert `reset`=0 at the 4th busy cycle → next cycle `busy`=0, `hi`=`lo`=0. No later update occurs.
- Back-to-back: mult 2×3 and, on the first IDLE cycle after it, multu 0xFFFFFFFF×2.
  - `lo`=6 appears, then `hi`=1, `lo`=0xFFFFFFFE.
  - No idle gap beyond one cycle of `start`.

Source files
------------

// File: rtl/mdu_if.sv
// HI/LO sequencer bundle between the E stage and mdu_seq.
// Pipeline side is master; the sequencer is slave.
interface mdu_if;
  logic [3:0]  md_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_sel, a, b, d_md_use,
    input  start, busy, stall_md,
    input  md_out, hi, lo
  );

  modport slave (
    input  md_sel, a, b, d_md_use,
    output start, busy, stall_md,
    output md_out, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle mult/div sequencer owning HI/LO.
// Result is computed at issue and committed after N busy cycles.
module mdu_seq #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_p, lo_p;
  logic        dz;

  logic op_mult, op_multu;
  logic op_div, op_divu;
  logic op_mfhi, op_mflo;
  logic op_mthi, op_mtlo;
  logic is_md, is_div;
  logic idle, start, done;

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_nz;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    op_mfhi  = 1'b0;
    op_mflo  = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    unique case (1'b1)
      (bus.md_sel == 4'd1): op_mult  = 1'b1;
      (bus.md_sel == 4'd2): op_multu = 1'b1;
      (bus.md_sel == 4'd3): op_div   = 1'b1;
      (bus.md_sel == 4'd4): op_divu  = 1'b1;
      (bus.md_sel == 4'd5): op_mfhi  = 1'b1;
      (bus.md_sel == 4'd6): op_mflo  = 1'b1;
      (bus.md_sel == 4'd7): op_mthi  = 1'b1;
      (bus.md_sel == 4'd8): op_mtlo  = 1'b1;
      default: ;
    endcase
  end

  assign is_div = op_div | op_divu;
  assign is_md  = op_mult | op_multu | is_div;
  assign idle   = (state == IDLE);
  assign start  = idle & is_md;
  assign done   = (state == BUSY) && (cnt == 4'd1);

  assign prod_s = {{32{bus.a[31]}}, bus.a}
                * {{32{bus.b[31]}}, bus.b};
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Divisor forced nonzero so the datapath never yields X.
  assign b_nz = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign q_s  = $signed(bus.a) / $signed(b_nz);
  assign r_s  = $signed(bus.a) % $signed(b_nz);
  assign q_u  = bus.a / b_nz;
  assign r_u  = bus.a % b_nz;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (1'b1)
      op_mult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      op_multu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      op_div: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      op_divu: begin
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = BUSY;
          cnt_n   = is_div ? 4'(DIV_CYCLES)
                           : 4'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (done) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      hi_p <= 32'd0;
      lo_p <= 32'd0;
      dz   <= 1'b0;
    end else begin
      if (start) begin
        hi_p <= res_hi;
        lo_p <= res_lo;
        dz   <= is_div & (bus.b == 32'd0);
      end
      if (idle & op_mthi) hi_q <= bus.a;
      if (idle & op_mtlo) lo_q <= bus.a;
      if (done & ~dz) begin
        hi_q <= hi_p;
        lo_q <= lo_p;
      end
    end
  end

  assign bus.start    = start;
  assign bus.busy     = (state == BUSY);
  assign bus.stall_md = bus.d_md_use
                      & (start | bus.busy);
  assign bus.md_out   = op_mfhi ? hi_q :
                        op_mflo ? lo_q : 32'd0;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq.
// Inputs change on negedge; outputs sampled away from posedge.
module tb_mdu_seq;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_if bus();

  mdu_seq #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.md_sel   = 4'd0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.d_md_use = 1'b0;
  endtask

  // Issue at current negedge; return start sample and busy length.
  task automatic run_op(
    input  logic [3:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        st,
    output int          n
  );
    bus.md_sel = op;
    bus.a      = x;
    bus.b      = y;
    #1 st = bus.start;
    @(negedge clk);
    bus.md_sel = 4'd0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h/%h exp 0/0",
               bus.hi, bus.lo);
    end
    checks++;
    if ({bus.start, bus.stall_md} !== 2'b00
        || bus.md_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_comb got %b%b %h exp 00 0",
               bus.start, bus.stall_md, bus.md_out);
    end
    @(negedge clk);
  endtask

  task automatic test_mult();
    logic st;
    int   n;
    run_op(4'd1, 32'hFFFFFFFD, 32'd5, st, n);
    checks++;
    if (st !== 1'b1 || n != 5) begin
      errors++;
      $display("FAIL mult_timing got st=%b n=%0d exp 1 5",
               st, n);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFF
        || bus.lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_res got %h/%h exp ffffffff/fffffff1",
               bus.hi, bus.lo);
    end
    run_op(4'd2, 32'hFFFFFFFD, 32'd5, st, n);
    checks++;
    if (st !== 1'b1 || n != 5) begin
      errors++;
      $display("FAIL multu_timing got st=%b n=%0d exp 1 5",
               st, n);
    end
    checks++;
    if (bus.hi !== 32'h00000004
        || bus.lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL multu_res got %h/%h exp 00000004/fffffff1",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    logic st;
    int   n;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, st, n);
    checks++;
    if (st !== 1'b1 || n != 10) begin
      errors++;
      $display("FAIL div_timing got st=%b n=%0d exp 1 10",
               st, n);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFF
        || bus.lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_res got %h/%h exp ffffffff/fffffffd",
               bus.hi, bus.lo);
    end
    run_op(4'd4, 32'd7, 32'd2, st, n);
    checks++;
    if (n != 10 || bus.hi !== 32'd1 || bus.lo !== 32'd3) begin
      errors++;
      $display("FAIL divu got n=%0d %h/%h exp 10 1/3",
               n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_zero();
    logic st;
    int   n;
    bus.md_sel = 4'd7;
    bus.a      = 32'h1234;
    @(negedge clk);
    bus.md_sel = 4'd8;
    bus.a      = 32'h5678;
    #1;
    checks++;
    if (bus.hi !== 32'h1234) begin
      errors++;
      $display("FAIL mthi got %h exp 1234", bus.hi);
    end
    @(negedge clk);
    bus.md_sel = 4'd6;
    #1;
    checks++;
    if (bus.lo !== 32'h5678 || bus.md_out !== 32'h5678) begin
      errors++;
      $display("FAIL mtlo got %h md_out %h exp 5678",
               bus.lo, bus.md_out);
    end
    @(negedge clk);
    run_op(4'd3, 32'd9, 32'd0, st, n);
    checks++;
    if (st !== 1'b1 || n != 10) begin
      errors++;
      $display("FAIL dz_timing got st=%b n=%0d exp 1 10",
               st, n);
    end
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
      errors++;
      $display("FAIL dz_hold got %h/%h exp 1234/5678",
               bus.hi, bus.lo);
    end
  endtask

  task automatic test_stall();
    int n;
    int bad;
    bus.d_md_use = 1'b1;
    bus.md_sel   = 4'd1;
    bus.a        = 32'h00010000;
    bus.b        = 32'h00030000;
    #1;
    checks++;
    if (bus.start !== 1'b1 || bus.stall_md !== 1'b1) begin
      errors++;
      $display("FAIL stall_issue got st=%b stall=%b exp 1 1",
               bus.start, bus.stall_md);
    end
    @(negedge clk);
    n   = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.md_sel = (i == 1) ? 4'd2 :
                   (i == 2) ? 4'd7 :
                   (i == 3) ? 4'd8 : 4'd0;
      bus.a = 32'hDEADBEEF;
      bus.b = 32'h7;
      #1;
      if (!bus.busy) break;
      n++;
      if (bus.stall_md !== 1'b1 || bus.start !== 1'b0)
        bad++;
      @(negedge clk);
    end
    bus.md_sel = 4'd0;
    #1;
    checks++;
    if (n != 5 || bad != 0) begin
      errors++;
      $display("FAIL stall_busy got n=%0d bad=%0d exp 5 0",
               n, bad);
    end
    checks++;
    if (bus.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got %b exp 0",
               bus.stall_md);
    end
    checks++;
    if (bus.hi !== 32'd3 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL stall_ignore got %h/%h exp 3/0",
               bus.hi, bus.lo);
    end
    checks++;
    if (bus.md_out !== 32'd0) begin
      errors++;
      $display("FAIL md_out_none got %h exp 0", bus.md_out);
    end
    bus.md_sel = 4'd5;
    #1;
    checks++;
    if (bus.md_out !== 32'd3 || bus.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL mfhi got %h stall=%b exp 3 0",
               bus.md_out, bus.stall_md);
    end
    bus.md_sel = 4'd11;
    #1;
    checks++;
    if (bus.start !== 1'b0 || bus.md_out !== 32'd0) begin
      errors++;
      $display("FAIL sel_none got st=%b %h exp 0 0",
               bus.start, bus.md_out);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sel_none_busy got %b exp 0", bus.busy);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.md_sel = 4'd4;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(negedge clk);
    bus.md_sel = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0
        || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got b=%b %h/%h exp 0 0/0",
               bus.busy, bus.hi, bus.lo);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0
        || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_late got b=%b %h/%h exp 0 0/0",
               bus.busy, bus.hi, bus.lo);
    end
    bus.md_sel = 4'd1;
    bus.a      = 32'd5;
    bus.b      = 32'd5;
    reset      = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    bus.md_sel = 4'd0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_issue got %b exp 0", bus.busy);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_issue_lo got %h exp 0", bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    int   n;
    run_op(4'd1, 32'd2, 32'd3, st, n);
    checks++;
    if (n != 5 || bus.lo !== 32'd6 || bus.hi !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first got n=%0d %h/%h exp 5 0/6",
               n, bus.hi, bus.lo);
    end
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, st, n);
    checks++;
    if (st !== 1'b1 || n != 5) begin
      errors++;
      $display("FAIL b2b_issue got st=%b n=%0d exp 1 5",
               st, n);
    end
    checks++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL b2b_res got %h/%h exp 1/fffffffe",
               bus.hi, bus.lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
